pkt_rx_buffer: RTL
==================

Name: pkt_rx_buffer

Overview:
- Store-and-forward packet buffer between the RGMII/GMII runtime's received 134b packet stream and the CPU user module (um_for_cpu) input.
- Accepts the valid-only stream, which cannot be back-pressured. Whole packets are committed only on tail; malformed, oversize or overflowing packets are dropped in full.
- Committed packets are replayed on a valid/ready stream. Drop/accept counters are exported for CPU status.

Parameters:
- ADDR_W, 8, log2 of buffer depth in 134b words (default 256 words).
- MAX_PKT_WORDS, 96, largest accepted packet in words (1536B); longer packets are dropped.
- LOCAL_MAC, 48'h0A0B0C0D0E0F, station MAC; used only under PKT_FILTER_EN.

Ports:
- clk  in  1  single clock (125 MHz domain).
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word strobe; no ready exists, so every strobed word must be consumed.
- in_data  in  134  [133:132] tag (01 head, 10 tail, 00 middle, 11 single-word), [131:128] byte-valid, [127:0] data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept; tie to 1 when the sink has no ready.
- out_data  out  134  same format as in_data.
- pkt_in_cnt  out  32  committed packets, wraps modulo 2^32.
- pkt_drop_cnt  out  32  dropped packets, wraps modulo 2^32.

Behaviour:
- Reset values: out_valid=0, out_data=0, both counters=0. Write, commit and read pointers are 0; write FSM is W_IDLE.
- Pointers are ADDR_W+1 bits. full = (wr_ptr - rd_ptr) == 2^ADDR_W. Output data is available when commit_ptr != rd_ptr.
- Write FSM:
  - W_IDLE: on head, write the word at wr_ptr and go to W_PKT; a single-word packet (11) commits immediately. Non-head words are ignored and not counted.
  - W_PKT: middle words are written. Tail is written, then commit_ptr <= wr_ptr+1 and pkt_in_cnt++ in the same cycle; return to W_IDLE.
  - W_PKT, new head: the current packet is aborted (wr_ptr <= commit_ptr, pkt_drop_cnt++), and the new head is written as the start of a fresh packet.
  - W_PKT, word arrives while full, or word count would exceed MAX_PKT_WORDS: wr_ptr <= commit_ptr, pkt_drop_cnt++, go to W_DROP.
  - W_DROP: all words are discarded until the tail, then go to W_IDLE. A head seen in W_DROP is treated as in W_IDLE.
- Commit latency: tail written in cycle T, commit_ptr visible T+1, earliest out_valid T+3 (one RAM read cycle plus the output register).
- Read side: first-word-fall-through via output register plus one skid word. out_valid and out_data stay stable while out_ready=0. With out_ready=1, throughput is one word per cycle.
- Simultaneous read and write in the same cycle are legal. Full is evaluated on the pre-update rd_ptr; a word that frees space in the same cycle does not rescue a packet already being dropped.
- Reset mid-packet: buffer contents are discarded. Input words before the next head are ignored. out_valid deasserts in the cycle after rst is sampled.
- Packets are never truncated or reordered; out_data is bit-identical to the input words.

Optional Feature:
- PKT_FILTER_EN defined: on head, dst MAC in_data[127:80] is compared with LOCAL_MAC and 48'hFFFFFFFFFFFF. On mismatch, pkt_drop_cnt++ and the FSM goes to W_DROP without writing, or stays in W_IDLE for a single-word packet.
- PKT_FILTER_EN undefined: all well-formed packets are accepted; LOCAL_MAC is unused.

Decomposition:
- Shared package pkt_pkg: PKT_W=134, tag constants TAG_HEAD=2'b01, TAG_TAIL=2'b10, TAG_MID=2'b00, TAG_SINGLE=2'b11, and the field-slice bit positions.
- Sub-module pkt_buf_ram: simple dual-port RAM, 2^ADDR_W x 134, one write port, registered 1-cycle read.

Test Plan:
- 4-word packet (head, 2 middle, tail) with out_ready=1 -> identical 4 words on out; out_valid first high 3 cycles after tail; pkt_in_cnt=1.
- 100-word packet with MAX_PKT_WORDS=96, followed by a 4-word packet -> only the 4-word packet is output; pkt_drop_cnt=1, pkt_in_cnt=1.
- out_ready=0 while 300 words are sent as 75 four-word packets (ADDR_W=8) -> 64 packets kept, 11 dropped. Then out_ready=1 -> 256 words out, in order.
- Head, middle, then a new head plus 3 more words -> first packet aborted; only the second 4-word packet is output; pkt_drop_cnt=1.
- rst asserted mid-packet, then middle and tail words, then a 4-word packet -> only the last packet is output; counters equal 1/0.
- PKT_FILTER_EN defined: dst FF:FF:FF:FF:FF:FF, LOCAL_MAC and 02:00:00:00:00:01 packets -> first two output; pkt_drop_cnt=1.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared definitions for the packet receive buffer: word format, tag encodings,
// field positions and the write-side FSM state type.
package pkt_pkg;

  localparam int PKT_W   = 134;
  localparam int TAG_HI  = 133;
  localparam int TAG_LO  = 132;
  localparam int BV_HI   = 131;
  localparam int BV_LO   = 128;
  localparam int DATA_HI = 127;
  localparam int DATA_LO = 0;
  localparam int DMAC_HI = 127;
  localparam int DMAC_LO = 80;

  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PKT  = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  // Bit 0 of the tag marks the first word of a packet, bit 1 the last word.
  function automatic logic tag_is_start(input logic [1:0] tag);
    return tag[0];
  endfunction

  function automatic logic tag_is_end(input logic [1:0] tag);
    return tag[1];
  endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Simple dual-port buffer RAM: one write port, one read port with a
// registered (1-cycle) read.
module pkt_buf_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 134
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_rx_buffer.sv
// Store-and-forward receive buffer: commits whole packets on tail, drops bad ones,
// replays committed words on a valid/ready stream. `PKT_FILTER_EN enables dst-MAC filtering.
//
// Output handshake: a word transfers on a cycle where out_valid && out_ready are both
// high at the rising edge; while out_valid is high and out_ready low, out_valid and
// out_data hold their values.
module pkt_rx_buffer
  import pkt_pkg::*;
#(
  parameter int          ADDR_W        = 8,
  parameter int          MAX_PKT_WORDS = 96,
  parameter logic [47:0] LOCAL_MAC     = 48'h0A0B0C0D0E0F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PKT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data,
  output logic [31:0]      pkt_in_cnt,
  output logic [31:0]      pkt_drop_cnt,
  output logic [1:0]       dbg_wr_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;
  localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_PKT_WORDS);

  wr_state_e         state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       in_cnt_q, in_cnt_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic [1:0]        drop_inc;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [PKT_W-1:0]  ram_rdata;

  logic [1:0]        in_tag;
  logic [PW-1:0]     base_ptr;
  logic              base_full;
  logic              wr_full;
  logic              mac_ok;

  assign in_tag = in_data[TAG_HI:TAG_LO];
  // A head arriving mid-packet restarts from the last committed position.
  assign base_ptr  = (state_q == W_PKT) ? commit_ptr_q : wr_ptr_q;
  assign base_full = (base_ptr - rd_ptr_q) == DEPTH_P;
  assign wr_full   = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

`ifdef PKT_FILTER_EN
  assign mac_ok = (in_data[DMAC_HI:DMAC_LO] == LOCAL_MAC) ||
                  (in_data[DMAC_HI:DMAC_LO] == {48{1'b1}});
`else
  logic unused_local_mac;
  assign unused_local_mac = ^LOCAL_MAC;
  assign mac_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_d        = cnt_q;
    in_cnt_d     = in_cnt_q;
    drop_inc     = 2'd0;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q[ADDR_W-1:0];
    if (in_valid) begin
      if (tag_is_start(in_tag)) begin
        if (state_q == W_PKT) drop_inc = 2'd1;
        wr_ptr_d = base_ptr;
        if (!mac_ok || base_full) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = tag_is_end(in_tag) ? W_IDLE : W_DROP;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = base_ptr[ADDR_W-1:0];
          wr_ptr_d  = base_ptr + PW'(1);
          if (tag_is_end(in_tag)) begin
            commit_ptr_d = base_ptr + PW'(1);
            in_cnt_d     = in_cnt_q + 32'd1;
            state_d      = W_IDLE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = W_PKT;
          end
        end
      end else if (state_q == W_PKT) begin
        if (wr_full || (cnt_q >= MAX_C)) begin
          wr_ptr_d = commit_ptr_q;
          drop_inc = 2'd1;
          state_d  = tag_is_end(in_tag) ? W_IDLE : W_DROP;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (tag_is_end(in_tag)) begin
            commit_ptr_d = wr_ptr_q + PW'(1);
            in_cnt_d     = in_cnt_q + 32'd1;
            state_d      = W_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end else if ((state_q == W_DROP) && tag_is_end(in_tag)) begin
        state_d = W_IDLE;
      end
    end
  end

  assign drop_cnt_d = drop_cnt_q + 32'(drop_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      cnt_q        <= '0;
      in_cnt_q     <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      cnt_q        <= cnt_d;
      in_cnt_q     <= in_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Read side: RAM read in flight, then output register backed by one skid word.
  logic             rd_pend_q, rd_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [PKT_W-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PKT_W-1:0] skid_q, skid_d;
  logic             rd_issue;
  logic             pop;
  logic [1:0]       occ;

  assign pop = out_valid_q && out_ready;
  assign occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
  // Only issue a read if its data is guaranteed a slot when it lands next cycle.
  assign rd_issue = (commit_ptr_q != rd_ptr_q) && ((occ - {1'b0, pop}) <= 2'd1);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_issue);
  assign rd_pend_d = rd_issue;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_q;
        skid_valid_d = rd_pend_q;
        skid_d       = ram_rdata;
      end else if (rd_pend_q) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rdata;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      skid_valid_d = 1'b1;
      skid_d       = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      rd_pend_q    <= rd_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  pkt_buf_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(PKT_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(in_data),
    .re_i   (rd_issue),
    .raddr_i(rd_ptr_q[ADDR_W-1:0]),
    .rdata_o(ram_rdata)
  );

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign pkt_in_cnt   = in_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
  assign dbg_wr_state = state_q;

endmodule
